// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store front end: the memory-op record
// and the issue width used by the LSU-facing queue.
package lsu_pkg;

  localparam int ISSUE_W = 2;
  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int PREG_W  = 7;
  localparam int ROB_W   = 8;

  // Access size encodings (log2 of the byte count)
  localparam logic [2:0] MEM_SIZE_B = 3'd0;
  localparam logic [2:0] MEM_SIZE_H = 3'd1;
  localparam logic [2:0] MEM_SIZE_W = 3'd2;
  localparam logic [2:0] MEM_SIZE_D = 3'd3;

  typedef struct packed {
    logic              is_store;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] store_data;
    logic [2:0]        size;
    logic [PREG_W-1:0] dest_phys;
    logic [ROB_W-1:0]  rob_idx;
  } mem_op_t;

endpackage

// File: rtl/miq_commit_cam.sv
// Tag match of every queue entry against the ROB commit ports; candidates are
// valid stores still waiting for their commit.
module miq_commit_cam
  import lsu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]              cand_i,
  input  logic [DEPTH-1:0][ROB_W-1:0]   entry_rob_i,
  input  logic [ISSUE_W-1:0]            commit_valid_i,
  input  logic [ISSUE_W-1:0][ROB_W-1:0] commit_rob_idx_i,
  output logic [DEPTH-1:0]              match_o
);

  // NOTE: every variable written in a combinational block gets a default first,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    match_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int p = 0; p < ISSUE_W; p++) begin
        if (cand_i[i] && commit_valid_i[p] && (entry_rob_i[i] == commit_rob_idx_i[p]))
          match_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_issue_queue.sv
// In-order memory-op queue in front of the LSU: two-wide enqueue with address
// generation, ROB-gated store issue, two-wide in-order issue, flush of uncommitted ops.
module mem_issue_queue
  import lsu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IMM_W = 12
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ISSUE_W-1:0]                enq_valid_i,
  input  logic [ISSUE_W-1:0]                enq_is_store_i,
  input  logic [ISSUE_W-1:0][ADDR_W-1:0]    enq_base_i,
  input  logic [ISSUE_W-1:0][IMM_W-1:0]     enq_imm_i,
  input  logic [ISSUE_W-1:0][DATA_W-1:0]    enq_store_data_i,
  input  logic [ISSUE_W-1:0][2:0]           enq_size_i,
  input  logic [ISSUE_W-1:0][PREG_W-1:0]    enq_dest_phys_i,
  input  logic [ISSUE_W-1:0][ROB_W-1:0]     enq_rob_idx_i,
  output logic                              enq_ready_o,
  input  logic [ISSUE_W-1:0]                commit_valid_i,
  input  logic [ISSUE_W-1:0][ROB_W-1:0]     commit_rob_idx_i,
  input  logic                              flush_i,
  input  logic                              lsu_ready_i,
  output logic [ISSUE_W-1:0]                op_valid_o,
  output logic [ISSUE_W-1:0]                op_is_store_o,
  output logic [ISSUE_W-1:0][ADDR_W-1:0]    op_addr_o,
  output logic [ISSUE_W-1:0][DATA_W-1:0]    op_store_data_o,
  output logic [ISSUE_W-1:0][2:0]           op_store_size_o,
  output logic [ISSUE_W-1:0][PREG_W-1:0]    op_dest_phys_o,
  output logic [ISSUE_W-1:0][ROB_W-1:0]     op_rob_idx_o,
  output logic [$clog2(DEPTH):0]            count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W:0] ptr_t;

  mem_op_t                   entries_q [DEPTH];
  logic [DEPTH-1:0]          valid_q, committed_q, valid_d, committed_d;
  logic [DEPTH-1:0]          cam_cand, cam_match, committed_now;
  logic [DEPTH-1:0][ROB_W-1:0] entry_rob;
  ptr_t                      head_q, tail_q, head_d, tail_d, count, prefix;
  logic [PTR_W-1:0]          head_idx, head1_idx, scan_idx, flush_off;
  logic                      prefix_run, elig0, elig1;
  logic [ISSUE_W-1:0]        slot, wr_en;
  logic [PTR_W-1:0]          wr_idx [ISSUE_W];
  mem_op_t                   op_q [ISSUE_W];

  assign count       = tail_q - head_q;
  assign count_o     = count;
  assign enq_ready_o = (count <= ptr_t'(DEPTH - 2));
  assign head_idx    = head_q[PTR_W-1:0];
  assign head1_idx   = head_idx + PTR_W'(1);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cam_cand[i]  = valid_q[i] && entries_q[i].is_store && !committed_q[i];
      entry_rob[i] = entries_q[i].rob_idx;
    end
  end

  miq_commit_cam #(.DEPTH(DEPTH)) u_commit_cam (
    .cand_i           (cam_cand),
    .entry_rob_i      (entry_rob),
    .commit_valid_i   (commit_valid_i),
    .commit_rob_idx_i (commit_rob_idx_i),
    .match_o          (cam_match)
  );

  // A commit arriving this cycle already makes its store eligible.
  assign committed_now = committed_q | cam_match;

  // Loads are held back during a flush; stores need their commit.
  assign elig0 = entries_q[head_idx].is_store  ? committed_now[head_idx]  : !flush_i;
  assign elig1 = entries_q[head1_idx].is_store ? committed_now[head1_idx] : !flush_i;
  assign slot[0] = lsu_ready_i && (count != '0) && elig0;
  assign slot[1] = slot[0] && (count > ptr_t'(1)) && elig1;

  // Length of the committed-store run starting at head; it survives a flush.
  always_comb begin
    prefix     = '0;
    prefix_run = 1'b1;
    scan_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_idx + PTR_W'(k);
      if (prefix_run && (ptr_t'(k) < count) && entries_q[scan_idx].is_store && committed_now[scan_idx])
        prefix = prefix + ptr_t'(1);
      else
        prefix_run = 1'b0;
    end
  end

  always_comb begin
    valid_d     = valid_q;
    committed_d = committed_now;
    tail_d      = tail_q;
    wr_en       = '0;
    wr_idx[0]   = tail_q[PTR_W-1:0];
    wr_idx[1]   = tail_q[PTR_W-1:0] + PTR_W'(enq_valid_i[0]);
    flush_off   = '0;
    head_d      = head_q + ptr_t'(slot[0]) + ptr_t'(slot[1]);
    if (slot[0]) begin
      valid_d[head_idx]     = 1'b0;
      committed_d[head_idx] = 1'b0;
    end
    if (slot[1]) begin
      valid_d[head1_idx]     = 1'b0;
      committed_d[head1_idx] = 1'b0;
    end
    if (flush_i) begin
      tail_d = head_q + prefix;
      for (int i = 0; i < DEPTH; i++) begin
        flush_off = PTR_W'(i) - head_idx;
        if (ptr_t'(flush_off) >= prefix) begin
          valid_d[i]     = 1'b0;
          committed_d[i] = 1'b0;
        end
      end
    end else if (enq_ready_o) begin
      wr_en  = enq_valid_i;
      tail_d = tail_q + ptr_t'(enq_valid_i[0]) + ptr_t'(enq_valid_i[1]);
      for (int p = 0; p < ISSUE_W; p++) begin
        if (wr_en[p]) begin
          valid_d[wr_idx[p]]     = 1'b1;
          committed_d[wr_idx[p]] = 1'b0;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      valid_q     <= '0;
      committed_q <= '0;
      op_valid_o  <= '0;
      for (int s = 0; s < ISSUE_W; s++) op_q[s] <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      valid_q     <= valid_d;
      committed_q <= committed_d;
      op_valid_o  <= slot;
      if (slot[0]) op_q[0] <= entries_q[head_idx];
      if (slot[1]) op_q[1] <= entries_q[head1_idx];
    end
  end

  // NOTE: payload storage has no reset; valid_q and the pointers decide what is live.
  always_ff @(posedge clk) begin
    for (int p = 0; p < ISSUE_W; p++) begin
      if (wr_en[p]) begin
        entries_q[wr_idx[p]].is_store   <= enq_is_store_i[p];
        entries_q[wr_idx[p]].addr       <= enq_base_i[p] + ADDR_W'($signed(enq_imm_i[p]));
        entries_q[wr_idx[p]].store_data <= enq_store_data_i[p];
        entries_q[wr_idx[p]].size       <= enq_size_i[p];
        entries_q[wr_idx[p]].dest_phys  <= enq_dest_phys_i[p];
        entries_q[wr_idx[p]].rob_idx    <= enq_rob_idx_i[p];
      end
    end
  end

  always_comb begin
    for (int s = 0; s < ISSUE_W; s++) begin
      op_is_store_o[s]   = op_q[s].is_store;
      op_addr_o[s]       = op_q[s].addr;
      op_store_data_o[s] = op_q[s].store_data;
      op_store_size_o[s] = op_q[s].size;
      op_dest_phys_o[s]  = op_q[s].dest_phys;
      op_rob_idx_o[s]    = op_q[s].rob_idx;
    end
  end

  // Dispatch must not present an op unless two entries are free, and sizes stop at 8 bytes.
  assert property (@(posedge clk) disable iff (!rst_n) !((|enq_valid_i) && !enq_ready_o));
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(enq_valid_i[0] && (enq_size_i[0] > MEM_SIZE_D)) &&
                   !(enq_valid_i[1] && (enq_size_i[1] > MEM_SIZE_D)));

endmodule
